vx_warp_ctrl: RTL
=================

VX_WARP_CTRL -- requirements
Module: VX_warp_ctrl

Interface
REQ-001 SHALL have parameter NUM_WARPS, default 4, number of hardware warps (power of 2, >=2).
REQ-002 SHALL have parameter NUM_THREADS, default 4, threads per warp.
REQ-003 SHALL have parameter NUM_BARRIERS, default 4, number of barrier ids (power of 2).
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high.
REQ-006 SHALL have port start  input  1  one-cycle kernel launch pulse.
REQ-007 SHALL have port startup_addr  input  32  launch PC for warp 0.
REQ-008 SHALL have ports tmc_valid/tmc_wid/tmc_tmask  input  1/log2(NUM_WARPS)/NUM_THREADS  thread-mask change for warp tmc_wid.
REQ-009 SHALL have ports wspawn_valid/wspawn_wmask/wspawn_pc  input  1/NUM_WARPS/32  warp spawn request.
REQ-010 SHALL have ports bar_valid/bar_wid/bar_id/bar_size_m1  input  1/log2(NUM_WARPS)/log2(NUM_BARRIERS)/log2(NUM_WARPS)  barrier arrival.
REQ-011 SHALL have ports unstall_valid/unstall_wid  input  1/log2(NUM_WARPS)  execution complete for a warp.
REQ-012 SHALL have ports sched_valid/sched_wid/sched_tmask/sched_pc  output  1/log2(NUM_WARPS)/NUM_THREADS/32  issue candidate.
REQ-013 SHALL have port sched_ready  input  1  downstream accepts candidate.
REQ-014 SHALL have port busy  output  1  high in RUN state.

Function
REQ-015 SHALL hold per-warp regs: active, stalled, barrier-blocked, tmask[NUM_THREADS], pc[32]; per-barrier arrival count[log2(NUM_WARPS)].
REQ-016 SHALL implement FSM IDLE->RUN on start; RUN->IDLE in the cycle after active mask becomes all-zero; start in RUN ignored.
REQ-017 SHALL, on start in IDLE, next cycle set warp 0 active, pc0=startup_addr, tmask0=all-ones, clear all stalled/blocked/counts.
REQ-018 SHALL form ready = active & ~stalled & ~blocked; sched_valid = RUN & |ready; outputs combinational from registers.
REQ-019 SHALL select sched_wid round-robin: lowest ready index strictly above last issued wid, wrapping; pointer reset value 0 with last = NUM_WARPS-1.
REQ-020 SHALL hold sched_wid stable while sched_valid & ~sched_ready unless that warp is cleared by a control input.
REQ-021 SHALL on handshake (sched_valid & sched_ready) set stalled[wid], pc[wid]+=4 (mod 2^32), advance RR pointer.
REQ-022 SHALL on unstall_valid clear stalled[unstall_wid]; unstall of a non-stalled warp ignored.
REQ-023 SHALL on tmc_valid write tmask[tmc_wid], clear stalled[tmc_wid]; tmc_tmask==0 clears active[tmc_wid].
REQ-024 SHALL on wspawn_valid, for each i>0 with wmask[i] and ~active[i], set active, pc=wspawn_pc, tmask all-ones, stalled=0; bit 0 and already-active warps ignored; also clears stalled of no warp.
REQ-025 SHALL on bar_valid clear stalled[bar_wid]; if count[bar_id]==bar_size_m1 release (clear blocked) all warps waiting on bar_id, do not block bar_wid, count:=0; else blocked[bar_wid]=1, record bar_id, count+=1.
REQ-026 SHALL, bar_size_m1==0, pass through immediately with no blocking.
REQ-027 SHALL give same-cycle priority per warp: handshake stall-set < unstall/tmc/bar clear; i.e. clear wins if same wid.
REQ-028 SHALL accept tmc, wspawn, bar, unstall, handshake all in the same cycle, applied independently per REQ-021..027.
REQ-029 SHALL ignore all control inputs in IDLE.
REQ-030 SHALL have 1-cycle latency: any state change visible on sched_* the cycle after the causing input.

Reset
REQ-031 SHALL on reset asynchronously force IDLE, all masks 0, tmask 0, pc 0, counts 0, RR last=NUM_WARPS-1; sched_valid=0, sched_wid=0, sched_tmask=0, sched_pc=0, busy=0.
REQ-032 SHALL, on reset during RUN, drop busy/sched_valid immediately and discard pending barriers.

Verification
REQ-033 SHALL cover launch: start, startup_addr=0x80000000, ready=1 -> next cycle sched_valid=1, wid=0, tmask=0xF, pc=0x80000000; busy=1.
REQ-034 SHALL cover spawn+RR: wspawn wmask=0xF pc=0x1000, all unstall each cycle, ready=1 -> issue order 0,1,2,3,0; warps 1-3 pc=0x1000,0x1000,0x1000.
REQ-035 SHALL cover barrier: 4 warps bar id=2 size_m1=3 -> first three blocked, sched_valid=0 once all stalled/blocked; fourth arrival releases all next cycle, count[2]=0.
REQ-036 SHALL cover termination: tmc tmask=0 for every active warp -> active=0, FSM IDLE next cycle, busy=0.
REQ-037 SHALL cover backpressure/collision: sched_ready=0 holds wid/pc 3 cycles; handshake + unstall same wid same cycle -> warp not stalled, pc+4.
REQ-038 SHALL cover mid-run reset: assert reset with 2 blocked warps -> all outputs zero asynchronously; fresh start works.

Source files
------------

// File: rtl/vx_warp_ctrl.sv
// Warp control: launch, spawn, thread-mask change, barriers and round-robin issue selection.
// Issue candidates are formed combinationally from registered per-warp state.
module vx_warp_ctrl #(
   parameter int unsigned NUM_WARPS    = 4,
   parameter int unsigned NUM_THREADS  = 4,
   parameter int unsigned NUM_BARRIERS = 4,
   localparam int unsigned WW = $clog2(NUM_WARPS),
   localparam int unsigned BW = $clog2(NUM_BARRIERS)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [31:0]            startup_addr,
   input  logic                   tmc_valid,
   input  logic [WW-1:0]          tmc_wid,
   input  logic [NUM_THREADS-1:0] tmc_tmask,
   input  logic                   wspawn_valid,
   input  logic [NUM_WARPS-1:0]   wspawn_wmask,
   input  logic [31:0]            wspawn_pc,
   input  logic                   bar_valid,
   input  logic [WW-1:0]          bar_wid,
   input  logic [BW-1:0]          bar_id,
   input  logic [WW-1:0]          bar_size_m1,
   input  logic                   unstall_valid,
   input  logic [WW-1:0]          unstall_wid,
   output logic                   sched_valid,
   output logic [WW-1:0]          sched_wid,
   output logic [NUM_THREADS-1:0] sched_tmask,
   output logic [31:0]            sched_pc,
   input  logic                   sched_ready,
   output logic                   busy
);

   typedef enum logic {StIdle, StRun} state_e;

   state_e                 r_state;
   logic [NUM_WARPS-1:0]   r_active;
   logic [NUM_WARPS-1:0]   r_stalled;
   logic [NUM_WARPS-1:0]   r_blocked;
   logic [NUM_THREADS-1:0] r_tmask   [NUM_WARPS];
   logic [31:0]            r_pc      [NUM_WARPS];
   logic [BW-1:0]          r_bar_id  [NUM_WARPS];
   logic [WW-1:0]          r_bar_cnt [NUM_BARRIERS];
   logic [WW-1:0]          r_last;
   logic                   r_hold_vld;
   logic [WW-1:0]          r_hold_wid;

   logic [NUM_WARPS-1:0]   w_ready;
   logic [WW-1:0]          w_rr_wid;
   logic [WW-1:0]          w_wid;
   logic                   w_run;
   logic                   w_fire;

   assign w_run   = (r_state == StRun);
   assign w_ready = r_active & ~r_stalled & ~r_blocked;

   // Scan from farthest to nearest so the nearest ready warp above r_last wins.
   always_comb begin
      logic [WW-1:0] idx;
      w_rr_wid = '0;
      idx      = '0;
      for (int i = NUM_WARPS; i >= 1; i--) begin
         idx = r_last + WW'(i);
         if (w_ready[idx]) w_rr_wid = idx;
      end
   end

   // A stalled-by-backpressure candidate keeps priority while it stays ready.
   assign w_wid = (r_hold_vld && w_ready[r_hold_wid]) ? r_hold_wid : w_rr_wid;

   assign sched_valid = w_run & (|w_ready);
   assign sched_wid   = w_wid;
   assign sched_tmask = r_tmask[w_wid];
   assign sched_pc    = r_pc[w_wid];
   assign busy        = w_run;
   assign w_fire      = sched_valid & sched_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= StIdle;
         r_active   <= '0;
         r_stalled  <= '0;
         r_blocked  <= '0;
         r_last     <= WW'(NUM_WARPS - 1);
         r_hold_vld <= 1'b0;
         r_hold_wid <= '0;
         for (int i = 0; i < NUM_WARPS; i++) begin
            r_tmask[i]  <= '0;
            r_pc[i]     <= '0;
            r_bar_id[i] <= '0;
         end
         for (int b = 0; b < NUM_BARRIERS; b++) r_bar_cnt[b] <= '0;
      end else begin
         case (r_state)
            StIdle: begin
               if (start) begin
                  r_state    <= StRun;
                  r_active   <= NUM_WARPS'(1);
                  r_stalled  <= '0;
                  r_blocked  <= '0;
                  r_tmask[0] <= '1;
                  r_pc[0]    <= startup_addr;
                  r_last     <= WW'(NUM_WARPS - 1);
                  r_hold_vld <= 1'b0;
                  for (int b = 0; b < NUM_BARRIERS; b++) r_bar_cnt[b] <= '0;
               end
            end
            StRun: begin
               if (r_active == '0) r_state <= StIdle;
               r_hold_vld <= sched_valid & ~sched_ready;
               r_hold_wid <= w_wid;

               // Handshake first so the clears below override the stall on the same warp.
               if (w_fire) begin
                  r_stalled[w_wid] <= 1'b1;
                  r_pc[w_wid]      <= r_pc[w_wid] + 32'd4;
                  r_last           <= w_wid;
               end

               if (wspawn_valid) begin
                  for (int i = 1; i < NUM_WARPS; i++) begin
                     if (wspawn_wmask[i] && !r_active[i]) begin
                        r_active[i]  <= 1'b1;
                        r_stalled[i] <= 1'b0;
                        r_pc[i]      <= wspawn_pc;
                        r_tmask[i]   <= '1;
                     end
                  end
               end

               if (unstall_valid) r_stalled[unstall_wid] <= 1'b0;

               if (tmc_valid) begin
                  r_tmask[tmc_wid]   <= tmc_tmask;
                  r_stalled[tmc_wid] <= 1'b0;
                  if (tmc_tmask == '0) r_active[tmc_wid] <= 1'b0;
               end

               if (bar_valid) begin
                  r_stalled[bar_wid] <= 1'b0;
                  if (r_bar_cnt[bar_id] == bar_size_m1) begin
                     for (int i = 0; i < NUM_WARPS; i++) begin
                        if (r_blocked[i] && (r_bar_id[i] == bar_id)) r_blocked[i] <= 1'b0;
                     end
                     r_bar_cnt[bar_id] <= '0;
                  end else begin
                     r_blocked[bar_wid] <= 1'b1;
                     r_bar_id[bar_wid]  <= bar_id;
                     r_bar_cnt[bar_id]  <= r_bar_cnt[bar_id] + WW'(1);
                  end
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

endmodule
